// File: rtl/eth_loopback_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eth_loopback_buf
// Brief    : Captures one received Ethernet payload into a byte RAM and, if
//            the frame checked out (good FCS, expected EtherType, no
//            overflow), replays it into the eth_tx byte-load interface and
//            kicks off transmission. Frames arriving while busy are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module eth_loopback_buf #(
  parameter int gAddr_Width = 11,
  parameter int gMax_Bytes  = 1500,
  parameter int gTx_Timeout = 4095
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic [7:0]  Recv_Byte,
  input  logic        Recv_Byte_Rdy,
  input  logic        Recv_Frame_End,
  input  logic        Recv_Crc_Valid,
  input  logic        Recv_EtherType_Valid,
  input  logic        Tx_En,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Rdy,
  output logic        Busy,
  output logic [15:0] Frame_Cnt,
  output logic [15:0] Drop_Cnt
);

  localparam int C_DEPTH = 1 << gAddr_Width;
  localparam int C_CNT_W = gAddr_Width + 1;
  localparam logic [C_CNT_W-1:0] C_MAX     = C_CNT_W'(gMax_Bytes);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

  // Kick-off timeout: WAIT_TX is left after gTx_Timeout cycles without a
  // Tx_En rise, so the timer terminal value is gTx_Timeout-1.
  localparam int C_TMO_LAST = (gTx_Timeout > 1) ? gTx_Timeout - 1 : 0;
  localparam int C_TMR_W    = (C_TMO_LAST > 1) ? $clog2(C_TMO_LAST + 1) : 1;
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(C_TMO_LAST);
  localparam logic [C_TMR_W-1:0] C_TMR_ONE  = C_TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_REPLAY  = 3'd2,
    S_KICK    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is asynchronous, release is retimed through
  // two flops so the FSM never leaves reset on a partial clock edge.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Two-stage reset release synchroniser
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [C_CNT_W-1:0]   r_wr_cnt;      // bytes stored for the current frame
  logic                 r_ovf;         // frame exceeded gMax_Bytes
  logic [C_CNT_W-1:0]   r_rd_cnt;      // replay read pointer
  logic                 r_byte_valid;
  logic                 r_pkt_rdy;
  logic [C_TMR_W-1:0]   r_timer;
  logic                 r_tx_seen;     // Tx_En rise observed in WAIT_TX
  logic [15:0]          r_frame_cnt;
  logic [15:0]          r_drop_cnt;
  logic [7:0]           r_ram_q;
  logic [7:0]           r_mem [C_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                   w_cap_full;
  logic                   w_ovf_next;
  logic                   w_accept;
  logic                   w_we;
  logic [gAddr_Width-1:0] w_waddr;
  logic                   w_drop_inc;

  // Overflow/accept decision includes a byte arriving with Recv_Frame_End
  always_comb begin
    w_cap_full = (r_wr_cnt >= C_MAX);
    if (r_state == S_IDLE) begin
      w_ovf_next = 1'b0;
    end else begin
      w_ovf_next = r_ovf | (Recv_Byte_Rdy & w_cap_full);
    end
    w_accept = Recv_Crc_Valid & Recv_EtherType_Valid & ~w_ovf_next;
  end

  // RAM write port: only IDLE (first byte) and CAPTURE (while room) store
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    if (Recv_Byte_Rdy) begin
      if (r_state == S_IDLE) begin
        w_we    = 1'b1;
        w_waddr = '0;
      end else if ((r_state == S_CAPTURE) && !w_cap_full) begin
        w_we    = 1'b1;
        w_waddr = r_wr_cnt[gAddr_Width-1:0];
      end
    end
  end

  // Every frame end that does not launch a replay counts as a drop
  always_comb begin
    w_drop_inc = 1'b0;
    if (Recv_Frame_End) begin
      case (r_state)
        S_IDLE:    w_drop_inc = ~Recv_Byte_Rdy | ~w_accept;
        S_CAPTURE: w_drop_inc = ~w_accept;
        default:   w_drop_inc = 1'b1;
      endcase
    end
  end

  // Byte RAM: synchronous write, synchronous read at the replay pointer
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= Recv_Byte;
    end
    r_ram_q <= r_mem[r_rd_cnt[gAddr_Width-1:0]];
  end

  // Main controller: capture, replay, kick-off, transmit wait and counters
  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_wr_cnt     <= '0;
      r_ovf        <= 1'b0;
      r_rd_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_pkt_rdy    <= 1'b0;
      r_timer      <= '0;
      r_tx_seen    <= 1'b0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_pkt_rdy    <= 1'b0;
      r_drop_cnt   <= r_drop_cnt + {15'd0, w_drop_inc};

      case (r_state)
        S_IDLE: begin
          if (Recv_Byte_Rdy) begin
            r_wr_cnt <= C_CNT_ONE;
            r_ovf    <= 1'b0;
            if (Recv_Frame_End) begin
              // Single-byte frame: decide immediately
              if (w_accept) begin
                r_rd_cnt <= '0;
                r_state  <= S_REPLAY;
              end
            end else begin
              r_state <= S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (Recv_Byte_Rdy) begin
            if (!w_cap_full) begin
              r_wr_cnt <= r_wr_cnt + C_CNT_ONE;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          if (Recv_Frame_End) begin
            if (w_accept) begin
              r_rd_cnt <= '0;
              r_state  <= S_REPLAY;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end

        S_REPLAY: begin
          // Read data lands in r_ram_q together with the valid flag
          r_byte_valid <= 1'b1;
          r_rd_cnt     <= r_rd_cnt + C_CNT_ONE;
          if ((r_rd_cnt + C_CNT_ONE) == r_wr_cnt) begin
            r_state <= S_KICK;
          end
        end

        S_KICK: begin
          // Last byte is on the output now; the pulse follows it directly
          r_pkt_rdy   <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_timer     <= '0;
          r_tx_seen   <= 1'b0;
          r_state     <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (!r_tx_seen) begin
            if (Tx_En) begin
              r_tx_seen <= 1'b1;
            end else if (r_timer == C_TMR_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_timer <= r_timer + C_TMR_ONE;
            end
          end else if (!Tx_En) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (data bus forced to zero outside valid cycles)
  // --------------------------------------------------------------------------
  assign Eth_Byte       = r_byte_valid ? r_ram_q : 8'h00;
  assign Eth_Byte_Valid = r_byte_valid;
  assign Eth_Pkt_Rdy    = r_pkt_rdy;
  assign Busy           = (r_state != S_IDLE);
  assign Frame_Cnt      = r_frame_cnt;
  assign Drop_Cnt       = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_loopback_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_loopback_buf
// Brief    : Self-checking bench for eth_loopback_buf: table of directed
//            frames, reset-abort sequence and randomized frames checked
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_loopback_buf;

  localparam int MAX_BYTES  = 1500;
  localparam int TX_TIMEOUT = 4095;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  recv_byte;
  logic        recv_byte_rdy;
  logic        recv_frame_end;
  logic        recv_crc_valid;
  logic        recv_et_valid;
  logic        tx_en;
  logic [7:0]  eth_byte;
  logic        eth_byte_valid;
  logic        eth_pkt_rdy;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  eth_loopback_buf dut (
    .Clk                 (clk),
    .Rstn                (rstn),
    .Recv_Byte           (recv_byte),
    .Recv_Byte_Rdy       (recv_byte_rdy),
    .Recv_Frame_End      (recv_frame_end),
    .Recv_Crc_Valid      (recv_crc_valid),
    .Recv_EtherType_Valid(recv_et_valid),
    .Tx_En               (tx_en),
    .Eth_Byte            (eth_byte),
    .Eth_Byte_Valid      (eth_byte_valid),
    .Eth_Pkt_Rdy         (eth_pkt_rdy),
    .Busy                (busy),
    .Frame_Cnt           (frame_cnt),
    .Drop_Cnt            (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  logic [7:0] rx_q[$];
  int   bursts = 0, burst_start = 0, last_valid_cyc = 0;
  int   pkt_cnt = 0, pkt_cyc = 0, inv_err = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (eth_byte_valid) begin
      rx_q.push_back(eth_byte);
      last_valid_cyc <= cyc;
      if (!prev_valid) begin
        bursts      <= bursts + 1;
        burst_start <= cyc;
      end
    end
    if (eth_pkt_rdy) begin
      pkt_cnt <= pkt_cnt + 1;
      pkt_cyc <= cyc;
    end
    inv_err <= inv_err + int'(eth_byte_valid && eth_pkt_rdy)
                       + int'(!eth_byte_valid && (eth_byte != 8'h00));
    prev_valid <= eth_byte_valid;
  end

  int n_checks = 0, n_pass = 0;
  logic [15:0] exp_frame = 16'd0, exp_drop = 16'd0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    recv_byte = 8'h00; recv_byte_rdy = 1'b0; recv_frame_end = 1'b0;
    recv_crc_valid = 1'b0; recv_et_valid = 1'b0;
  endtask

  function automatic logic [7:0] gen_byte(input logic [31:0] pat, input int i);
    return pat[31-8*(i%4) -: 8] ^ 8'(i/4);
  endfunction

  // Drives one frame; returns the cycle index carrying Recv_Frame_End.
  // Returns positioned in the cycle right after the frame end.
  task automatic drive_frame(input int len, input logic [31:0] pat, input bit crc,
                             input bit et, input bit end_last, output int fe_cyc);
    fe_cyc = 0;
    for (int i = 0; i < len; i++) begin
      recv_byte = gen_byte(pat, i);
      recv_byte_rdy = 1'b1;
      if (end_last && i == len - 1) begin
        recv_frame_end = 1'b1; recv_crc_valid = crc; recv_et_valid = et;
        fe_cyc = cyc;
      end
      tick();
    end
    clear_inputs();
    if (!end_last) begin
      recv_frame_end = 1'b1; recv_crc_valid = crc; recv_et_valid = et;
      fe_cyc = cyc;
      tick();
      clear_inputs();
    end
  endtask

  // Full frame transaction with all timing/content checks
  task automatic run_frame(input int len, input logic [31:0] pat, input bit crc,
                           input bit et, input bit end_last, input bit fe_rep,
                           input bit stray, input int tx_len, input bit exp_replay,
                           input int exp_drop_inc, input string tag);
    int rx0, b0, p0, fe_cyc, n, got, nbad;
    rx0 = rx_q.size(); b0 = bursts; p0 = pkt_cnt;
    drive_frame(len, pat, crc, et, end_last, fe_cyc);
    exp_drop = exp_drop + 16'(exp_drop_inc);
    if (!exp_replay) begin
      check({tag, "_busy_after_drop"}, busy, 0);
      repeat (4) tick();
      check({tag, "_no_replay"}, rx_q.size() - rx0, 0);
      check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
      check({tag, "_frame_cnt"}, frame_cnt, exp_frame);
    end else begin
      exp_frame = exp_frame + 16'd1;
      n = 0;
      while (pkt_cnt == p0 && n < len + 20) begin
        if (fe_rep && n == 0) begin
          recv_frame_end = 1'b1; recv_crc_valid = 1'b1; recv_et_valid = 1'b1;
        end
        if (stray) begin
          recv_byte_rdy = 1'($urandom_range(0, 1));
          recv_byte = 8'($urandom);
        end
        tick();
        clear_inputs();
        n++;
      end
      check({tag, "_pkt_seen"}, (pkt_cnt != p0), 1);
      check({tag, "_frame_cnt"}, frame_cnt, exp_frame);
      if (tx_len == 0) begin
        while (cyc < pkt_cyc + TX_TIMEOUT - 1) tick();
        check({tag, "_busy_before_timeout"}, busy, 1);
        tick();
        check({tag, "_timeout_idle"}, busy, 0);
      end else begin
        repeat (2) tick();
        tx_en = 1'b1;
        repeat (tx_len) tick();
        tx_en = 1'b0;
        check({tag, "_busy_during_tx"}, busy, 1);
        tick();
        check({tag, "_idle_after_txfall"}, busy, 0);
      end
      got = rx_q.size() - rx0;
      check({tag, "_nbytes"}, got, len);
      nbad = 0;
      for (int i = 0; i < len && i < got; i++)
        if (rx_q[rx0 + i] !== gen_byte(pat, i)) nbad++;
      check({tag, "_data_errs"}, nbad, 0);
      check({tag, "_bursts"}, bursts - b0, 1);
      check({tag, "_first_valid_cyc"}, burst_start, fe_cyc + 2);
      check({tag, "_pkt_after_last"}, pkt_cyc, last_valid_cyc + 1);
      check({tag, "_pkt_pulses"}, pkt_cnt - p0, 1);
      check({tag, "_frame_cnt_end"}, frame_cnt, exp_frame);
      check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    end
  endtask

  // Standalone frame end while idle
  task automatic idle_fe();
    recv_frame_end = 1'b1;
    recv_crc_valid = 1'($urandom_range(0, 1));
    recv_et_valid  = 1'($urandom_range(0, 1));
    tick();
    clear_inputs();
    exp_drop = exp_drop + 16'd1;
    check("idle_fe_drop", drop_cnt, exp_drop);
  endtask

  typedef struct {
    int          len;
    logic [31:0] pat;
    bit          crc, et, end_last, fe_rep, stray;
    int          tx_len;
    bit          exp_replay;
    int          exp_drop_inc;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int fe_c, p0;
    //          len   pattern       crc et end fer str tx  rep drop
    vecs[0] = '{4,    32'hDEADBEEF, 1, 1, 0, 0, 0, 20, 1, 0};
    vecs[1] = '{10,   32'h12345678, 0, 1, 0, 0, 0, 3,  0, 1};
    vecs[2] = '{1501, 32'hA5C30F71, 1, 1, 0, 0, 0, 3,  0, 1};
    vecs[3] = '{1500, 32'h3C5A96E1, 1, 1, 0, 0, 1, 4,  1, 0};
    vecs[4] = '{3,    32'h11223344, 1, 1, 1, 1, 0, 2,  1, 1};
    vecs[5] = '{1,    32'h77000000, 1, 1, 1, 0, 1, 1,  1, 0};
    vecs[6] = '{6,    32'h0BADF00D, 1, 0, 1, 0, 0, 2,  0, 1};
    vecs[7] = '{2,    32'hFACE0001, 1, 1, 0, 0, 0, 0,  1, 0};
    vecs[8] = '{1501, 32'h5EED1234, 1, 1, 1, 0, 0, 2,  0, 1};
    vecs[9] = '{1500, 32'h0F0F55AA, 1, 1, 1, 0, 0, 5,  1, 0};

    rstn = 1'b0; tx_en = 1'b0; clear_inputs();
    repeat (3) tick();
    check("rst_eth_byte", eth_byte, 0);
    check("rst_byte_valid", eth_byte_valid, 0);
    check("rst_pkt_rdy", eth_pkt_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // Frame end on the first edge after release must be ignored
    rstn = 1'b1; recv_frame_end = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("sync_release_ignore", drop_cnt, 0);
    repeat (3) tick();

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].len, vecs[v].pat, vecs[v].crc, vecs[v].et, vecs[v].end_last,
                vecs[v].fe_rep, vecs[v].stray, vecs[v].tx_len, vecs[v].exp_replay,
                vecs[v].exp_drop_inc, $sformatf("vec%0d", v));
      repeat (2) tick();
    end
    idle_fe();

    // Reset asserted while the second replay byte is on the bus
    p0 = pkt_cnt;
    drive_frame(6, 32'hC0FFEE42, 1'b1, 1'b1, 1'b0, fe_c);
    tick(); tick();
    check("abort_second_valid", eth_byte_valid, 1);
    check("abort_second_byte", eth_byte, gen_byte(32'hC0FFEE42, 1));
    #2 rstn = 1'b0;
    #1;
    check("abort_eth_byte", eth_byte, 0);
    check("abort_byte_valid", eth_byte_valid, 0);
    check("abort_pkt_rdy", eth_pkt_rdy, 0);
    check("abort_busy", busy, 0);
    check("abort_frame_cnt", frame_cnt, 0);
    check("abort_drop_cnt", drop_cnt, 0);
    repeat (3) tick();
    rstn = 1'b1;
    exp_frame = 16'd0; exp_drop = 16'd0;
    repeat (30) tick();
    check("abort_no_pkt", pkt_cnt - p0, 0);
    check("abort_idle", busy, 0);
    run_frame(7, 32'h600DCAFE, 1, 1, 0, 0, 0, 5, 1, 0, "post_abort");

    // Randomized frames against the frame-level model
    for (int f = 0; f < 30; f++) begin
      int len, txl;
      bit crc, et, el, fr, st, rep;
      if ($urandom_range(0, 9) == 0) len = $urandom_range(MAX_BYTES - 5, MAX_BYTES + 5);
      else len = $urandom_range(1, 40);
      crc = ($urandom_range(0, 3) != 0);
      et  = ($urandom_range(0, 3) != 0);
      el  = 1'($urandom_range(0, 1));
      rep = crc && et && (len <= MAX_BYTES);
      fr  = rep && ($urandom_range(0, 2) == 0);
      st  = rep && ($urandom_range(0, 1) == 0);
      txl = $urandom_range(1, 8);
      run_frame(len, $urandom, crc, et, el, fr, st, txl, rep,
                int'(!rep) + int'(fr), $sformatf("rnd%0d", f));
      if ($urandom_range(0, 3) == 0) idle_fe();
      tick();
    end

    check("output_invariants", inv_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
